// File: rtl/demod_record_fifo.sv
// Record FIFO behind the QPD lock-in demodulator: sequence-tagged records, registered FWFT output, overflow counting.
// Optional build macro DEMOD_FIFO_TIMESTAMP_EN adds a free-running cycle timestamp (ts_o) to every record.
module demod_record_fifo #(
    parameter int DEPTH     = 16,
    parameter int DATA_BITS = 24,
    parameter int OVF_BITS  = 16
) (
    input  logic                       clk_i,
    input  logic                       reset_ni,
    input  logic                       tick_i,
    input  logic [DATA_BITS-1:0]       x1_i,
    input  logic [DATA_BITS-1:0]       x2_i,
    input  logic [DATA_BITS-1:0]       i1_i,
    input  logic [DATA_BITS-1:0]       i2_i,
    input  logic                       clear_i,
    input  logic                       rd_i,
    output logic                       valid_o,
    output logic [31:0]                x1_o,
    output logic [31:0]                x2_o,
    output logic [31:0]                i1_o,
    output logic [31:0]                i2_o,
    output logic [31:0]                seq_o,
    output logic [$clog2(DEPTH)+1:0]   level_o,
    output logic                       full_o,
`ifdef DEMOD_FIFO_TIMESTAMP_EN
    output logic [31:0]                ts_o,
`endif
    output logic [OVF_BITS-1:0]        overflow_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int LW = AW + 2;
`ifdef DEMOD_FIFO_TIMESTAMP_EN
    localparam int REC_W = 6 * 32;
`else
    localparam int REC_W = 5 * 32;
`endif

    logic [REC_W-1:0]    mem_q [DEPTH];
    logic [REC_W-1:0]    head_q, head_d;
    logic [REC_W-1:0]    wr_rec;
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]       mem_cnt;
    logic [31:0]         seq_q, seq_d;
    logic [OVF_BITS-1:0] ovf_q, ovf_d;
    logic                valid_q, valid_d;
    logic                mem_empty, mem_full, pop, wr_en;
`ifdef DEMOD_FIFO_TIMESTAMP_EN
    logic [31:0]         ts_cnt_q, ts_cnt_d;
`endif

    function automatic logic [31:0] sext(input logic [DATA_BITS-1:0] v);
        return {{(32-DATA_BITS){v[DATA_BITS-1]}}, v};
    endfunction

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        mem_cnt   = wr_ptr_q - rd_ptr_q;
        mem_empty = (mem_cnt == '0);
        mem_full  = (mem_cnt == PW'(DEPTH));
        // Head refill reads only the pre-write memory state, which forbids a tick-to-output bypass.
        pop       = !clear_i && !mem_empty && (!valid_q || rd_i);
        wr_en     = !clear_i && tick_i && (!mem_full || pop);

`ifdef DEMOD_FIFO_TIMESTAMP_EN
        ts_cnt_d  = ts_cnt_q + 32'd1;
        wr_rec    = {ts_cnt_q, sext(x1_i), sext(x2_i), sext(i1_i), sext(i2_i), seq_q};
`else
        wr_rec    = {sext(x1_i), sext(x2_i), sext(i1_i), sext(i2_i), seq_q};
`endif

        seq_d    = tick_i ? seq_q + 32'd1 : seq_q;
        wr_ptr_d = wr_ptr_q + PW'(wr_en);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        ovf_d    = ovf_q;
        valid_d  = valid_q;
        head_d   = head_q;

        if (tick_i && !wr_en && !clear_i && (ovf_q != '1)) begin
            ovf_d = ovf_q + OVF_BITS'(1);
        end

        if (pop) begin
            head_d  = mem_q[rd_ptr_q[AW-1:0]];
            valid_d = 1'b1;
        end else if (rd_i) begin
            valid_d = 1'b0;
        end

        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = '0;
            valid_d  = 1'b0;
            head_d   = '0;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            seq_q    <= '0;
            ovf_q    <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
`ifdef DEMOD_FIFO_TIMESTAMP_EN
            ts_cnt_q <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            seq_q    <= seq_d;
            ovf_q    <= ovf_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
`ifdef DEMOD_FIFO_TIMESTAMP_EN
            ts_cnt_q <= ts_cnt_d;
`endif
        end
    end

    // NOTE: the record memory is not reset; the pointers alone decide which slots are live.
    always_ff @(posedge clk_i) begin
        if (reset_ni && wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
        end
    end

`ifdef DEMOD_FIFO_TIMESTAMP_EN
    assign {ts_o, x1_o, x2_o, i1_o, i2_o, seq_o} = head_q;
`else
    assign {x1_o, x2_o, i1_o, i2_o, seq_o} = head_q;
`endif
    assign valid_o        = valid_q;
    assign level_o        = LW'(mem_cnt) + LW'(valid_q);
    assign full_o         = mem_full;
    assign overflow_cnt_o = ovf_q;

endmodule
